// File: rtl/seven_segment_scanner_if.sv
// Pin-side bundle of the seven-segment scanner. The master drives the data and strobe
// inputs; the slave drives the anode, segment and frame outputs.
interface seven_segment_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] VALUE;
  logic [NUM_DIGITS-1:0]   DP;
  logic [NUM_DIGITS-1:0]   BLINK_EN;
  logic                    LOAD;
  logic                    BLANK_LZ;
  logic [NUM_DIGITS-1:0]   ANODE;
  logic [7:0]              SEGMENT;
  logic                    FRAME;

  modport master (
    output VALUE, DP, BLINK_EN, LOAD, BLANK_LZ,
    input  ANODE, SEGMENT, FRAME
  );

  modport slave (
    input  VALUE, DP, BLINK_EN, LOAD, BLANK_LZ,
    output ANODE, SEGMENT, FRAME
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment driver: shadowed hex value, internal decode,
// leading-zero blanking and per-digit blinking, with registered anode/segment outputs.
module seven_segment_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input logic CLK,
  input logic RST,
  seven_segment_scanner_if.slave bus
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Bit i set when nibble i and every nibble above it are zero; digit 0 is never blanked.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] v);
    logic [NUM_DIGITS-1:0] m;
    logic                  all_zero;
    m        = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero = all_zero & (v[4*i +: 4] == 4'h0);
      m[i]     = all_zero;
    end
    return m;
  endfunction

  function automatic logic [7:0] compose_segment(input logic [3:0] nib, input logic dp,
                                                 input logic blank, input logic blink_off);
    logic [7:0] seg;
    if (blink_off)  seg = 8'hFF;
    else if (blank) seg = {~dp, 7'h7F};
    else            seg = {~dp, decode_hex(nib)};
    return seg;
  endfunction

  // Stage 0: scan counters, blink phase and shadow registers
  logic [CW-1:0]           cnt_p0;
  logic [IW-1:0]           idx_p0;
  logic [FW-1:0]           fcnt_p0;
  logic                    phase_p0;
  logic [4*NUM_DIGITS-1:0] value_p0;
  logic [NUM_DIGITS-1:0]   dp_p0;
  logic [NUM_DIGITS-1:0]   blink_p0;

  logic step_p0;
  logic wrap_p0;

  assign step_p0 = (cnt_p0 == CNT_LAST);
  assign wrap_p0 = step_p0 && (idx_p0 == IDX_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_p0   <= '0;
      idx_p0   <= '0;
      fcnt_p0  <= '0;
      phase_p0 <= 1'b0;
      value_p0 <= '0;
      dp_p0    <= '0;
      blink_p0 <= '0;
    end else begin
      cnt_p0 <= step_p0 ? '0 : cnt_p0 + 1'b1;
      if (step_p0) idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
      if (wrap_p0) begin
        if (fcnt_p0 == FCNT_LAST) begin
          fcnt_p0  <= '0;
          phase_p0 <= ~phase_p0;
        end else begin
          fcnt_p0 <= fcnt_p0 + 1'b1;
        end
      end
      if (bus.LOAD) begin
        value_p0 <= bus.VALUE;
        dp_p0    <= bus.DP;
        blink_p0 <= bus.BLINK_EN;
      end
    end
  end

  logic [3:0]            nibs_p0 [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank_p0;
  logic [7:0]            seg_next_p0;

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) nibs_p0[i] = value_p0[4*i +: 4];
    blank_p0    = bus.BLANK_LZ ? lz_mask(value_p0) : '0;
    seg_next_p0 = compose_segment(nibs_p0[idx_p0], dp_p0[idx_p0], blank_p0[idx_p0],
                                  phase_p0 && blink_p0[idx_p0]);
  end

  // Stage 1: registered pin drivers
  logic [NUM_DIGITS-1:0] anode_p1;
  logic [7:0]            segment_p1;
  logic                  frame_p1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      anode_p1   <= '1;
      segment_p1 <= 8'hFF;
      frame_p1   <= 1'b0;
    end else begin
      anode_p1   <= ~(NUM_DIGITS'(1) << idx_p0);
      segment_p1 <= seg_next_p0;
      frame_p1   <= wrap_p0;
    end
  end

  assign bus.ANODE   = anode_p1;
  assign bus.SEGMENT = segment_p1;
  assign bus.FRAME   = frame_p1;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench: a cycle-time reference model predicts every output word of a 4-digit
// and a 1-digit scanner; a negedge monitor pops and compares.
module tb_seven_segment_scanner;
  localparam int ND = 4;
  localparam int R  = 4;
  localparam int BF = 2;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  seven_segment_scanner_if #(.NUM_DIGITS(ND)) bus4();
  seven_segment_scanner_if #(.NUM_DIGITS(1))  bus1();

  seven_segment_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(R), .BLINK_FRAMES(BF)) dut4 (
    .CLK(CLK), .RST(RST), .bus(bus4)
  );
  seven_segment_scanner #(.NUM_DIGITS(1), .REFRESH_DIV(R), .BLINK_FRAMES(BF)) dut1 (
    .CLK(CLK), .RST(RST), .bus(bus1)
  );

  assign bus1.VALUE    = bus4.VALUE[3:0];
  assign bus1.DP       = bus4.DP[0];
  assign bus1.BLINK_EN = bus4.BLINK_EN[0];
  assign bus1.LOAD     = bus4.LOAD;
  assign bus1.BLANK_LZ = bus4.BLANK_LZ;

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int compared   = 0;
  int mismatched = 0;

  // Expected word {FRAME, ANODE(4, unused bits 0), SEGMENT} after the n-th edge since reset.
  function automatic logic [12:0] model(int nd, int n, logic [15:0] v, logic [3:0] dp,
                                        logic [3:0] bl, logic blz);
    int         t, idx, ph;
    logic [3:0] nib;
    logic [7:0] seg;
    logic [3:0] an;
    logic       fr;
    t   = n - 1;
    idx = (t / R) % nd;
    ph  = (t / (R * nd * BF)) % 2;
    nib = 4'((v >> (4 * idx)) & 16'hF);
    seg = {~dp[idx], dec_tab[nib]};
    if (blz && idx != 0 && (v >> (4 * idx)) == 16'h0) seg[6:0] = 7'h7F;
    if (ph == 1 && bl[idx]) seg = 8'hFF;
    an  = 4'((~(32'd1 << idx)) & ((32'd1 << nd) - 1));
    fr  = (n % (R * nd)) == 0;
    return {fr, an, seg};
  endfunction

  logic [12:0] q4 [$];
  logic [12:0] q1 [$];

  // Reference model: shadow contents and time since reset, advanced on every edge.
  initial begin
    int          n;
    logic [15:0] sh_val;
    logic [3:0]  sh_dp, sh_bl;
    n = 0; sh_val = '0; sh_dp = '0; sh_bl = '0;
    forever begin
      @(posedge CLK);
      if (RST) begin
        n = 0; sh_val = '0; sh_dp = '0; sh_bl = '0;
        q4.push_back({1'b0, 4'hF, 8'hFF});
        q1.push_back({1'b0, 4'h1, 8'hFF});
      end else begin
        n++;
        q4.push_back(model(ND, n, sh_val, sh_dp, sh_bl, bus4.BLANK_LZ));
        q1.push_back(model(1, n, {12'h000, sh_val[3:0]}, {3'b000, sh_dp[0]},
                           {3'b000, sh_bl[0]}, bus4.BLANK_LZ));
        if (bus4.LOAD) begin
          sh_val = bus4.VALUE; sh_dp = bus4.DP; sh_bl = bus4.BLINK_EN;
        end
      end
    end
  end

  // Monitor: one output word per cycle from each instance, sampled on the falling edge.
  initial begin
    logic [12:0] exp_w, act_w;
    forever begin
      @(negedge CLK);
      if (q4.size() > 0) begin
        exp_w = q4.pop_front();
        act_w = {bus4.FRAME, bus4.ANODE, bus4.SEGMENT};
        compared++;
        if (act_w !== exp_w) begin
          mismatched++;
          $display("FAIL out4 t=%0t got frame=%b anode=%h seg=%h want frame=%b anode=%h seg=%h",
                   $time, act_w[12], act_w[11:8], act_w[7:0], exp_w[12], exp_w[11:8], exp_w[7:0]);
        end
      end
      if (q1.size() > 0) begin
        exp_w = q1.pop_front();
        act_w = {bus1.FRAME, 3'b000, bus1.ANODE, bus1.SEGMENT};
        compared++;
        if (act_w !== exp_w) begin
          mismatched++;
          $display("FAIL out1 t=%0t got frame=%b anode=%h seg=%h want frame=%b anode=%h seg=%h",
                   $time, act_w[12], act_w[11:8], act_w[7:0], exp_w[12], exp_w[11:8], exp_w[7:0]);
        end
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge CLK);
      bus4.LOAD = 1'b0;
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    @(negedge CLK);
    bus4.VALUE = v; bus4.DP = dp; bus4.BLINK_EN = bl; bus4.LOAD = 1'b1;
    @(negedge CLK);
    bus4.LOAD = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    RST = 1'b1;
    bus4.VALUE = '0; bus4.DP = '0; bus4.BLINK_EN = '0; bus4.LOAD = 1'b0; bus4.BLANK_LZ = 1'b0;
    idle(2);
    load(16'hFFFF, 4'hF, 4'hF);
    @(negedge CLK);
    RST = 1'b0;
    idle(40);

    load(16'h12AF, 4'b0100, 4'b0000);
    idle(20);

    load(16'h0050, 4'b0000, 4'b0000);
    bus4.BLANK_LZ = 1'b1;
    idle(20);
    bus4.BLANK_LZ = 1'b0;
    idle(20);
    load(16'h0000, 4'b0000, 4'b0000);
    bus4.BLANK_LZ = 1'b1;
    idle(20);
    bus4.BLANK_LZ = 1'b0;

    load(16'h8888, 4'b0000, 4'b0001);
    idle(140);

    for (int k = 0; k < 16; k++) begin
      load({12'h000, 4'(k)}, 4'b0000, 4'b0000);
      idle(16);
    end

    for (int c = 0; c < 1500; c++) begin
      @(negedge CLK);
      for (int i = 0; i < 4; i++) v[4*i +: 4] = ($urandom % 2 == 1) ? 4'($urandom) : 4'h0;
      bus4.VALUE    = v;
      bus4.DP       = 4'($urandom);
      bus4.BLINK_EN = 4'($urandom);
      bus4.LOAD     = ($urandom % 8) == 0;
      if ($urandom % 16 == 0) bus4.BLANK_LZ = ~bus4.BLANK_LZ;
      RST           = ($urandom % 200) == 0;
      if (RST) bus4.LOAD = 1'b1;
    end

    @(negedge CLK);
    RST = 1'b0;
    load(16'h3C5A, 4'b1010, 4'b0000);
    idle(7);
    @(negedge CLK);
    RST = 1'b1; bus4.VALUE = 16'hFFFF; bus4.DP = 4'hF; bus4.BLINK_EN = 4'hF; bus4.LOAD = 1'b1;
    @(negedge CLK);
    RST = 1'b0; bus4.LOAD = 1'b0;
    idle(40);

    @(negedge CLK);
    #1;
    compared++;
    if (q4.size() != 0 || q1.size() != 0) begin
      mismatched++;
      $display("FAIL drain got %0d/%0d pending want 0/0", q4.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
